// File: rtl/osnt_bram_dp_pipe.sv
// ---------------------------------------------------------------------------
// osnt_bram_dp_pipe
//
// True-dual-port, single-clock packet-buffer RAM. Each port is byte
// addressed and has byte-lane write enables. An optional output register
// stage can be added. Read-during-write behaviour is selectable. When both
// ports touch the same word in the same cycle, port A wins on shared lanes,
// and every such collision is counted for host diagnostics.
//
// Parameters
//   ADDR_WIDTH   byte-address width per port
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_LSB     byte-offset bits dropped when forming the word index
//   OUT_REG      0: rddata one cycle after request, 1: two cycles
//   WRITE_FIRST  0: read returns old word, 1: read returns merged new word
//   CNT_WIDTH    collision counter width
//
// Ports (x = a, b)
//   axis_aclk, axis_resetn        clock, async active-low reset
//   bram_addr_x                   byte address
//   bram_en_x                     access request (read, plus write if any we)
//   bram_we_x                     byte-lane write enables
//   bram_wrdata_x                 write data
//   bram_rddata_x                 read data, held between valid strobes
//   bram_rdvalid_x                one-cycle strobe marking new rddata
//   collision_clr                 synchronous clear of counter and flag
//   collision_cnt                 saturating collision count
//   collision_flag                sticky collision indicator
// ---------------------------------------------------------------------------
module osnt_bram_dp_pipe #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 800,
    parameter int ADDR_LSB    = 6,
    parameter int OUT_REG     = 1,
    parameter int WRITE_FIRST = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                      axis_aclk,
    input  logic                      axis_resetn,

    input  logic [ADDR_WIDTH-1:0]     bram_addr_a,
    input  logic                      bram_en_a,
    input  logic [DATA_WIDTH/8-1:0]   bram_we_a,
    input  logic [DATA_WIDTH-1:0]     bram_wrdata_a,
    output logic [DATA_WIDTH-1:0]     bram_rddata_a,
    output logic                      bram_rdvalid_a,

    input  logic [ADDR_WIDTH-1:0]     bram_addr_b,
    input  logic                      bram_en_b,
    input  logic [DATA_WIDTH/8-1:0]   bram_we_b,
    input  logic [DATA_WIDTH-1:0]     bram_wrdata_b,
    output logic [DATA_WIDTH-1:0]     bram_rddata_b,
    output logic                      bram_rdvalid_b,

    input  logic                      collision_clr,
    output logic [CNT_WIDTH-1:0]      collision_cnt,
    output logic                      collision_flag
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int WORD_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int DEPTH     = 1 << WORD_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [WORD_W-1:0]     idx_t;

    word_t mem [DEPTH];

    // Byte-offset bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bram_addr_a[ADDR_LSB-1:0], bram_addr_b[ADDR_LSB-1:0]};

    // Accesses are suppressed entirely while reset is held, so neither
    // writes nor reads are issued in that window.
    logic                 acc_a, acc_b;
    logic [NUM_LANES-1:0] we_a, we_b;
    idx_t                 idx_a, idx_b;
    logic                 same_word, collision;

    assign acc_a     = bram_en_a & axis_resetn;
    assign acc_b     = bram_en_b & axis_resetn;
    assign we_a      = acc_a ? bram_we_a : '0;
    assign we_b      = acc_b ? bram_we_b : '0;
    assign idx_a     = bram_addr_a[ADDR_WIDTH-1:ADDR_LSB];
    assign idx_b     = bram_addr_b[ADDR_WIDTH-1:ADDR_LSB];
    assign same_word = acc_a & acc_b & (idx_a == idx_b);
    assign collision = same_word & ((|we_a) | (|we_b));

    // NOTE: the storage array has no reset; clearing a RAM costs a full
    // sweep and blocks block-RAM inference, so contents survive axis_resetn.
    always_ff @(posedge axis_aclk) begin
        // Port B lanes are applied first; port A's assignment to the same
        // lane comes later in the block and therefore wins.
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we_b[i]) mem[idx_b][i*8 +: 8] <= bram_wrdata_b[i*8 +: 8];
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we_a[i]) mem[idx_a][i*8 +: 8] <= bram_wrdata_a[i*8 +: 8];
        end
    end

    // Read data selection. mem[] here is the pre-edge contents, i.e. the
    // read-first view. Write-first overlays this cycle's lanes from both
    // ports when they hit the same word, with port A taking priority.
    word_t rd_next_a, rd_next_b;

    // NOTE: every always_comb output gets a default on entry so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        rd_next_a = mem[idx_a];
        rd_next_b = mem[idx_b];
        if (WRITE_FIRST != 0) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we_a[i])
                    rd_next_a[i*8 +: 8] = bram_wrdata_a[i*8 +: 8];
                else if (same_word && we_b[i])
                    rd_next_a[i*8 +: 8] = bram_wrdata_b[i*8 +: 8];

                if (same_word && we_a[i])
                    rd_next_b[i*8 +: 8] = bram_wrdata_a[i*8 +: 8];
                else if (we_b[i])
                    rd_next_b[i*8 +: 8] = bram_wrdata_b[i*8 +: 8];
            end
        end
    end

    // First read stage: data loads only on an issued read and holds otherwise.
    logic  s1_valid_a, s1_valid_b;
    word_t s1_data_a,  s1_data_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            s1_valid_a <= 1'b0;
            s1_valid_b <= 1'b0;
            s1_data_a  <= '0;
            s1_data_b  <= '0;
        end else begin
            s1_valid_a <= acc_a;
            s1_valid_b <= acc_b;
            if (acc_a) s1_data_a <= rd_next_a;
            if (acc_b) s1_data_b <= rd_next_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic  s2_valid_a, s2_valid_b;
            word_t s2_data_a,  s2_data_b;

            always_ff @(posedge axis_aclk or negedge axis_resetn) begin
                if (!axis_resetn) begin
                    s2_valid_a <= 1'b0;
                    s2_valid_b <= 1'b0;
                    s2_data_a  <= '0;
                    s2_data_b  <= '0;
                end else begin
                    s2_valid_a <= s1_valid_a;
                    s2_valid_b <= s1_valid_b;
                    if (s1_valid_a) s2_data_a <= s1_data_a;
                    if (s1_valid_b) s2_data_b <= s1_data_b;
                end
            end

            assign bram_rddata_a  = s2_data_a;
            assign bram_rdvalid_a = s2_valid_a;
            assign bram_rddata_b  = s2_data_b;
            assign bram_rdvalid_b = s2_valid_b;
        end else begin : g_no_out_reg
            assign bram_rddata_a  = s1_data_a;
            assign bram_rdvalid_a = s1_valid_a;
            assign bram_rddata_b  = s1_data_b;
            assign bram_rdvalid_b = s1_valid_b;
        end
    endgenerate

    // Collision diagnostics. A clear that coincides with a collision restarts
    // the count at one rather than losing that event.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            collision_cnt  <= '0;
            collision_flag <= 1'b0;
        end else if (collision_clr) begin
            collision_cnt  <= collision ? CNT_WIDTH'(1) : '0;
            collision_flag <= collision;
        end else if (collision) begin
            if (collision_cnt != CNT_MAX) collision_cnt <= collision_cnt + 1'b1;
            collision_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_osnt_bram_dp_pipe.sv
// ---------------------------------------------------------------------------
// Bench for osnt_bram_dp_pipe. Two instances share one stimulus stream:
//   u_dut_rf : OUT_REG=1, WRITE_FIRST=0, CNT_WIDTH=2
//   u_dut_wf : OUT_REG=0, WRITE_FIRST=1, CNT_WIDTH=4
// A behavioural model (word array, per-channel expectation queues and
// counter arithmetic) predicts every output on every cycle.
// Channels: 0 = rf port A, 1 = rf port B, 2 = wf port A, 3 = wf port B.
// ---------------------------------------------------------------------------
module tb_osnt_bram_dp_pipe;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int NL = DW / 8;
    localparam int NW = 16;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic          en_a = 1'b0, en_b = 1'b0;
    logic [NL-1:0] we_a = '0, we_b = '0;
    logic [DW-1:0] wd_a = '0, wd_b = '0;
    logic          clr = 1'b0;

    logic [DW-1:0] rd_data  [4];
    logic          rd_valid [4];
    logic [1:0]    cnt_r;
    logic [3:0]    cnt_w;
    logic          flag_r, flag_w;

    always #5 clk = ~clk;

    osnt_bram_dp_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LSB(6),
        .OUT_REG(1), .WRITE_FIRST(0), .CNT_WIDTH(2)
    ) u_dut_rf (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .bram_addr_a(addr_a), .bram_en_a(en_a), .bram_we_a(we_a), .bram_wrdata_a(wd_a),
        .bram_rddata_a(rd_data[0]), .bram_rdvalid_a(rd_valid[0]),
        .bram_addr_b(addr_b), .bram_en_b(en_b), .bram_we_b(we_b), .bram_wrdata_b(wd_b),
        .bram_rddata_b(rd_data[1]), .bram_rdvalid_b(rd_valid[1]),
        .collision_clr(clr), .collision_cnt(cnt_r), .collision_flag(flag_r)
    );

    osnt_bram_dp_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LSB(6),
        .OUT_REG(0), .WRITE_FIRST(1), .CNT_WIDTH(4)
    ) u_dut_wf (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .bram_addr_a(addr_a), .bram_en_a(en_a), .bram_we_a(we_a), .bram_wrdata_a(wd_a),
        .bram_rddata_a(rd_data[2]), .bram_rdvalid_a(rd_valid[2]),
        .bram_addr_b(addr_b), .bram_en_b(en_b), .bram_we_b(we_b), .bram_wrdata_b(wd_b),
        .bram_rddata_b(rd_data[3]), .bram_rdvalid_b(rd_valid[3]),
        .collision_clr(clr), .collision_cnt(cnt_w), .collision_flag(flag_w)
    );

    // ---------------- reference model state ----------------
    logic [DW-1:0] m_mem [NW];
    exp_t          exp_q [4][$];
    logic [DW-1:0] m_last [4];
    int            m_cnt [2];
    int            m_cnt_max [2] = '{3, 15};
    bit            m_flag [2];
    int            cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            exp_q[c].delete();
            m_last[c] = '0;
        end
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_flag[d] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < 4; c++) begin
            bit exp_v;
            exp_v = (exp_q[c].size() > 0) && (exp_q[c][0].due == cyc);
            if (exp_v) m_last[c] = exp_q[c].pop_front().data;
            n_checks++;
            if (rd_valid[c] !== exp_v) begin
                n_errors++;
                $display("FAIL rdvalid ch%0d cyc%0d: got %b expected %b", c, cyc, rd_valid[c], exp_v);
            end
            n_checks++;
            if (rd_data[c] !== m_last[c]) begin
                n_errors++;
                $display("FAIL rddata ch%0d cyc%0d: got %h expected %h", c, cyc, rd_data[c], m_last[c]);
            end
        end
        n_checks++;
        if (cnt_r !== 2'(m_cnt[0]) || flag_r !== m_flag[0]) begin
            n_errors++;
            $display("FAIL counter rf cyc%0d: got cnt=%0d flag=%b expected cnt=%0d flag=%b",
                     cyc, cnt_r, flag_r, m_cnt[0], m_flag[0]);
        end
        n_checks++;
        if (cnt_w !== 4'(m_cnt[1]) || flag_w !== m_flag[1]) begin
            n_errors++;
            $display("FAIL counter wf cyc%0d: got cnt=%0d flag=%b expected cnt=%0d flag=%b",
                     cyc, cnt_w, flag_w, m_cnt[1], m_flag[1]);
        end
    endtask

    // Apply the currently driven inputs for one clock edge, predicting the
    // result from the behavioural rules, then check all outputs after the edge.
    task automatic step();
        bit acc_a, acc_b, same, col;
        int ia, ib;
        logic [DW-1:0] old_a, old_b, wf_a, wf_b;
        acc_a = rst_n && en_a;
        acc_b = rst_n && en_b;
        ia    = int'(addr_a[AW-1:6]);
        ib    = int'(addr_b[AW-1:6]);
        same  = acc_a && acc_b && (ia == ib);
        old_a = m_mem[ia];
        old_b = m_mem[ib];
        wf_a  = old_a;
        wf_b  = old_b;
        for (int l = 0; l < NL; l++) begin
            if (acc_a && we_a[l])      wf_a[l*8 +: 8] = wd_a[l*8 +: 8];
            else if (same && we_b[l])  wf_a[l*8 +: 8] = wd_b[l*8 +: 8];
            if (same && we_a[l])       wf_b[l*8 +: 8] = wd_a[l*8 +: 8];
            else if (acc_b && we_b[l]) wf_b[l*8 +: 8] = wd_b[l*8 +: 8];
        end
        if (acc_a) begin
            exp_q[0].push_back('{due: cyc + 2, data: old_a});
            exp_q[2].push_back('{due: cyc + 1, data: wf_a});
        end
        if (acc_b) begin
            exp_q[1].push_back('{due: cyc + 2, data: old_b});
            exp_q[3].push_back('{due: cyc + 1, data: wf_b});
        end
        for (int l = 0; l < NL; l++) begin
            if (acc_b && we_b[l]) m_mem[ib][l*8 +: 8] = wd_b[l*8 +: 8];
        end
        for (int l = 0; l < NL; l++) begin
            if (acc_a && we_a[l]) m_mem[ia][l*8 +: 8] = wd_a[l*8 +: 8];
        end
        col = same && ((we_a != '0) || (we_b != '0));
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (clr) begin
                    m_cnt[d]  = col ? 1 : 0;
                    m_flag[d] = col;
                end else if (col) begin
                    m_cnt[d]  = (m_cnt[d] < m_cnt_max[d]) ? m_cnt[d] + 1 : m_cnt[d];
                    m_flag[d] = 1'b1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = '0; wd_a = '0; addr_a = '0;
        en_b = 1'b0; we_b = '0; wd_b = '0; addr_b = '0;
        clr  = 1'b0;
    endtask

    task automatic set_a(input bit en, input logic [AW-1:0] addr,
                         input logic [NL-1:0] we, input logic [DW-1:0] data);
        en_a = en; addr_a = addr; we_a = we; wd_a = data;
    endtask

    task automatic set_b(input bit en, input logic [AW-1:0] addr,
                         input logic [NL-1:0] we, input logic [DW-1:0] data);
        en_b = en; addr_b = addr; we_b = we; wd_b = data;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (exp_q[c].size() != 0) begin
                n_errors++;
                $display("FAIL drain ch%0d: got %0d reads outstanding expected 0", c, exp_q[c].size());
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (rd_valid[c] !== 1'b0 || rd_data[c] !== '0) begin
                n_errors++;
                $display("FAIL %s ch%0d: got valid=%b data=%h expected 0/0", name, c, rd_valid[c], rd_data[c]);
            end
        end
        n_checks++;
        if (cnt_r !== '0 || flag_r !== 1'b0 || cnt_w !== '0 || flag_w !== 1'b0) begin
            n_errors++;
            $display("FAIL %s counters: got %0d/%b %0d/%b expected all 0", name, cnt_r, flag_r, cnt_w, flag_w);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        model_reset();
        check_zero_outputs("reset_state");
        set_a(1, 10'h040, '1, {8{8'h77}});   // ignored while in reset
        repeat (2) step();
        idle();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_init();
        for (int w = 0; w < NW; w++) begin
            set_a(1, 10'(w << 6), '1, '0);
            step();
        end
        drain();
    endtask

    task automatic test_full_word();
        set_a(1, 10'h0C0, '1, {8{8'hA5}});
        step();
        idle();
        set_b(1, 10'h0C0, '0, '0);
        step();
        idle();
        n_checks++;
        if (rd_valid[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL full_word early valid: got %b expected 0", rd_valid[1]);
        end
        step();
        n_checks++;
        if (rd_valid[1] !== 1'b1 || rd_data[1] !== {8{8'hA5}}) begin
            n_errors++;
            $display("FAIL full_word readback: got %b/%h expected 1/%h", rd_valid[1], rd_data[1], {8{8'hA5}});
        end
        drain();
    endtask

    task automatic test_partial_lanes();
        set_a(1, 10'h0C0, '1, {8{8'hFF}});
        step();
        set_a(1, 10'h0C0, 8'h0F, 64'h0000_0000_1122_3344);
        step();
        idle();
        set_b(1, 10'h0FF, '0, '0);   // low bits alias to word 3
        step();
        n_checks++;
        if (rd_data[3] !== 64'hFFFF_FFFF_1122_3344) begin
            n_errors++;
            $display("FAIL partial_lanes: got %h expected %h", rd_data[3], 64'hFFFF_FFFF_1122_3344);
        end
        drain();
    endtask

    task automatic test_write_write();
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_a(1, 10'h140, 8'h03, {8{8'hAA}});
        set_b(1, 10'h140, 8'h06, {8{8'hBB}});
        step();
        n_checks++;
        if (cnt_r !== 2'd1 || flag_r !== 1'b1) begin
            n_errors++;
            $display("FAIL write_write counter: got %0d/%b expected 1/1", cnt_r, flag_r);
        end
        idle();
        set_a(1, 10'h140, '0, '0);
        step();
        n_checks++;
        if (rd_data[2][23:0] !== 24'hBBAAAA) begin
            n_errors++;
            $display("FAIL write_write lanes: got %h expected bbaaaa", rd_data[2][23:0]);
        end
        drain();
    endtask

    task automatic test_read_during_write();
        set_a(1, 10'h1C0, '1, {8{8'h5A}});
        set_b(1, 10'h1C0, '0, '0);
        step();
        n_checks++;
        if (rd_data[3] !== {8{8'h5A}}) begin
            n_errors++;
            $display("FAIL rdw write_first: got %h expected %h", rd_data[3], {8{8'h5A}});
        end
        idle();
        step();
        n_checks++;
        if (rd_valid[1] !== 1'b1 || rd_data[1] !== '0) begin
            n_errors++;
            $display("FAIL rdw read_first: got %b/%h expected 1/0", rd_valid[1], rd_data[1]);
        end
        drain();
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_a(1, 10'h080, 8'h01, 64'h12);
        set_b(1, 10'h080, '0, '0);
        repeat (5) step();
        n_checks++;
        if (cnt_r !== 2'd3 || cnt_w !== 4'd5) begin
            n_errors++;
            $display("FAIL saturation: got rf=%0d wf=%0d expected 3/5", cnt_r, cnt_w);
        end
        clr = 1'b1;
        step();
        n_checks++;
        if (cnt_r !== 2'd1 || flag_r !== 1'b1 || cnt_w !== 4'd1) begin
            n_errors++;
            $display("FAIL clr_with_collision: got %0d/%b %0d expected 1/1 1", cnt_r, flag_r, cnt_w);
        end
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (cnt_r !== 2'd0 || flag_r !== 1'b0 || flag_w !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_alone: got %0d/%b/%b expected 0/0/0", cnt_r, flag_r, flag_w);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            set_a(1, 10'(i << 6), '0, '0);
            set_b(1, 10'((15 - i) << 6), '0, '0);
            step();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_a($urandom_range(0, 3) != 0, {4'($urandom_range(0, 3)), 6'($urandom)},
                  ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00,
                  {32'($urandom), 32'($urandom)});
            set_b($urandom_range(0, 3) != 0, {4'($urandom_range(0, 3)), 6'($urandom)},
                  ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00,
                  {32'($urandom), 32'($urandom)});
            clr = ($urandom_range(0, 15) == 0);
            step();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        set_b(1, 10'h0C0, '0, '0);
        step();
        idle();
        rst_n = 1'b0;
        set_a(1, 10'h0C0, '1, {8{8'hDE}});   // must not land in memory
        #1;
        model_reset();
        check_zero_outputs("reset_midflight");
        repeat (2) step();
        idle();
        rst_n = 1'b1;
        #2;
        step();
        set_b(1, 10'h0C0, '0, '0);
        step();
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_init();
        test_full_word();
        test_partial_lanes();
        test_write_write();
        test_read_during_write();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/osnt_bram_dp_pipe.md
# osnt_bram_dp_pipe

Parametrised true-dual-port, single-clock packet-buffer RAM with byte-lane write enables and byte-addressed ports. It replaces the fixed 64-byte-stride replay/capture BRAM used behind the OSNT generator and monitor AXI-BRAM paths. It adds:
- a configurable word stride;
- an optional output pipeline register with read-valid strobes;
- selectable read-during-write semantics;
- deterministic cross-port collision resolution with a saturating collision counter for host diagnostics.

## Interface
Parameters:
- ADDR_WIDTH, 20, byte-address width per port
- DATA_WIDTH, 800, word width in bits; must be a multiple of 8
- ADDR_LSB, 6, byte-offset bits ignored in word indexing; depth = 2^(ADDR_WIDTH-ADDR_LSB)
- OUT_REG, 1, 0 = rddata one cycle after request, 1 = extra output register stage
- WRITE_FIRST, 0, 0 = read-first (old data), 1 = write-first (merged new bytes)
- CNT_WIDTH, 16, collision counter width

Ports (x = a, b; both ports are identical):
- axis_aclk  in  1  single clock for both ports
- axis_resetn  in  1  asynchronous active-low reset
- bram_addr_x  in  ADDR_WIDTH  byte address; word index = addr[ADDR_WIDTH-1:ADDR_LSB]
- bram_en_x  in  1  access request (read, plus write when any we bit set)
- bram_we_x  in  DATA_WIDTH/8  byte-lane write enables, qualified by en
- bram_wrdata_x  in  DATA_WIDTH  write data
- bram_rddata_x  out  DATA_WIDTH  read data
- bram_rdvalid_x  out  1  one-cycle strobe, rddata valid
- collision_clr  in  1  synchronous clear of counter and flag
- collision_cnt  out  CNT_WIDTH  saturating collision count
- collision_flag  out  1  sticky, set on any collision

## Operation
- Each enabled access performs a read of the addressed word. The read is issued even when writes are present.
- Writes update only the lanes with we[i]=1. Low ADDR_LSB address bits are ignored.
- Read data, read-first (WRITE_FIRST=0): the returned word is the memory contents before this cycle's writes from either port.
- Read data, write-first (WRITE_FIRST=1): the returned word is the old word with lanes written this cycle merged in. Merging covers both ports when word indices match. On lanes written by both ports, port A data is used.
- Collision: both en=1, equal word index, and at least one port has a nonzero we.
- Write/write overlap: lanes enabled on both ports take port A data. Lanes enabled on only one port take that port's data.
- Each collision cycle increments collision_cnt by 1. The counter saturates at 2^CNT_WIDTH-1.
- collision_flag sets on any collision and stays set until cleared.
- collision_clr with no collision that cycle: next cycle cnt=0, flag=0.
- collision_clr in a collision cycle: next cycle cnt=1, flag=1.
- Memory contents are not reset or initialised by axis_resetn.
- While axis_resetn=0, en and we on both ports are ignored: no writes, no reads issued.

## Timing
- Request in cycle N. With OUT_REG=0, rdvalid_x=1 and rddata_x valid in cycle N+1. With OUT_REG=1, both appear in cycle N+2.
- Back-to-back requests give one rdvalid per cycle at full throughput, with no bubbles.
- rddata_x holds its last valid value when rdvalid_x=0. It loads only on a valid stage.
- Counter and flag update one cycle after the collision or clear cycle.
- Reset values: bram_rddata_x=0, bram_rdvalid_x=0, collision_cnt=0, collision_flag=0. All pipeline valid bits are cleared.
- Reset asserted mid-operation flushes in-flight reads asynchronously. Those reads never produce rdvalid.
- The first request accepted after reset release is on the first rising edge with axis_resetn=1.

## Test plan
- Port A writes 0xA5 to all lanes of word 3 (addr 0xC0), then port B reads addr 0xC0 with OUT_REG=1 -> B rdvalid exactly 2 cycles after request, rddata all-0xA5.
- Port A writes lanes 0-3 only with 0x11223344 over a word preloaded with all-0xFF -> readback has lanes 0-3 = 0x44,0x33,0x22,0x11, remaining lanes 0xFF. Addr low bits 0x3F must alias to the same word.
- Same-cycle write/write to word 5: A writes lanes 0-1 with 0xAA, B writes lanes 1-2 with 0xBB -> lane0=0xAA, lane1=0xAA, lane2=0xBB. collision_cnt=1, collision_flag=1.
- Read-during-write on word 7 (old all-0x00; A writes all-0x5A while B reads): WRITE_FIRST=0 -> B gets all-0x00; WRITE_FIRST=1 -> B gets all-0x5A. collision_cnt increments in both cases.
- CNT_WIDTH=2 with 5 consecutive collisions -> cnt saturates at 3. collision_clr together with a collision -> cnt=1, flag=1. A following clear alone -> 0, 0.
- axis_resetn pulsed low between a request and its rdvalid (OUT_REG=1), with a write presented during reset -> no rdvalid, outputs 0. Memory holds pre-reset contents and the reset-cycle write is absent.
